// File: rtl/regdec_scoreboard.sv
// Register-address decoder with a per-register pending-write scoreboard.
// Produces registered one-hot writeback enables and combinational RAW/WAW issue stalls.
module regdec_scoreboard #(
  parameter int ADDR_W      = 3,
  parameter bit ZERO_REG_HW = 1'b0
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     issue_valid,
  input  logic [ADDR_W-1:0]        issue_dst,
  input  logic [ADDR_W-1:0]        issue_src_a,
  input  logic [ADDR_W-1:0]        issue_src_b,
  output logic                     issue_ready,
  input  logic                     wb_valid,
  input  logic [ADDR_W-1:0]        wb_addr,
  output logic [(2**ADDR_W)-1:0]   wb_we,
  output logic [(2**ADDR_W)-1:0]   busy,
  output logic [ADDR_W:0]          busy_count,
  input  logic                     flush,
  output logic                     err_spurious
);

  localparam int NREG = 2**ADDR_W;
  // Bit 0 set only when register 0 is hardwired; masks it out of every path.
  localparam logic [NREG-1:0] HW_MASK = {{(NREG-1){1'b0}}, ZERO_REG_HW};

  function automatic logic [ADDR_W:0] popcount(input logic [NREG-1:0] v);
    logic [ADDR_W:0] c;
    c = '0;
    for (int i = 0; i < NREG; i++) begin
      c = c + {{ADDR_W{1'b0}}, v[i]};
    end
    return c;
  endfunction

  function automatic logic [NREG-1:0] onehot(input logic [ADDR_W-1:0] a);
    logic [NREG-1:0] o;
    o    = '0;
    o[a] = 1'b1;
    return o;
  endfunction

  logic [NREG-1:0]   r_busy;
  logic [NREG-1:0]   r_wb_we;
  logic [ADDR_W:0]   r_busy_count;
  logic              r_err;

  logic [NREG-1:0]   w_wb_hit;
  logic [NREG-1:0]   w_hz;
  logic [NREG-1:0]   w_busy_nxt;
  logic [NREG-1:0]   w_we_nxt;
  logic              w_accept;
  logic              w_err_set;

  // Same-cycle writeback bypass and per-register hazard vector.
  always_comb begin
    w_wb_hit = '0;
    for (int r = 0; r < NREG; r++) begin
      w_wb_hit[r] = wb_valid && (wb_addr == ADDR_W'(r));
    end
    w_hz        = r_busy & ~w_wb_hit & ~HW_MASK;
    issue_ready = ~flush & ~(w_hz[issue_src_a] | w_hz[issue_src_b] | w_hz[issue_dst]);
    w_accept    = issue_valid & issue_ready;
  end

  // Next scoreboard state: flush beats a new issue, a new issue beats a writeback clear.
  always_comb begin
    w_busy_nxt = r_busy;
    if (flush) begin
      w_busy_nxt = '0;
    end else begin
      w_busy_nxt = r_busy & ~w_wb_hit;
      if (w_accept) begin
        w_busy_nxt[issue_dst] = 1'b1;
      end else begin
        w_busy_nxt = w_busy_nxt;
      end
    end
    w_busy_nxt = w_busy_nxt & ~HW_MASK;
  end

  // Writeback decode and spurious-writeback detection.
  always_comb begin
    w_we_nxt  = '0;
    w_err_set = 1'b0;
    if (wb_valid) begin
      w_we_nxt  = onehot(wb_addr) & ~HW_MASK;
      w_err_set = ~flush & ~r_busy[wb_addr] & ~HW_MASK[wb_addr];
    end else begin
      w_we_nxt  = '0;
      w_err_set = 1'b0;
    end
  end

  // Registered scoreboard, write enables, count and sticky error.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_busy       <= '0;
      r_wb_we      <= '0;
      r_busy_count <= '0;
      r_err        <= 1'b0;
    end else begin
      r_busy       <= w_busy_nxt;
      r_wb_we      <= w_we_nxt;
      r_busy_count <= popcount(w_busy_nxt);
      r_err        <= r_err | w_err_set;
    end
  end

  assign busy         = r_busy;
  assign wb_we        = r_wb_we;
  assign busy_count   = r_busy_count;
  assign err_spurious = r_err;

endmodule

// File: tb/tb_regdec_scoreboard.sv
// Randomized and directed bench for regdec_scoreboard: one default instance
// (ADDR_W=3) and one with a hardwired register 0 (ADDR_W=4), each against a reference model.
module tb_regdec_scoreboard;

  typedef struct {
    logic [63:0] busy;
    logic [63:0] we;
    logic        err;
  } st_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic       issue_valid, wb_valid, flush;
  logic [2:0] issue_dst, issue_src_a, issue_src_b, wb_addr;
  logic       issue_ready, err_spurious;
  logic [7:0] wb_we, busy;
  logic [3:0] busy_count;

  logic        z_issue_valid, z_wb_valid, z_flush;
  logic [3:0]  z_issue_dst, z_issue_src_a, z_issue_src_b, z_wb_addr;
  logic        z_issue_ready, z_err_spurious;
  logic [15:0] z_wb_we, z_busy;
  logic [4:0]  z_busy_count;

  regdec_scoreboard #(.ADDR_W(3), .ZERO_REG_HW(1'b0)) dut (
    .clk(clk), .rst_n(rst_n), .issue_valid(issue_valid), .issue_dst(issue_dst),
    .issue_src_a(issue_src_a), .issue_src_b(issue_src_b), .issue_ready(issue_ready),
    .wb_valid(wb_valid), .wb_addr(wb_addr), .wb_we(wb_we), .busy(busy),
    .busy_count(busy_count), .flush(flush), .err_spurious(err_spurious));

  regdec_scoreboard #(.ADDR_W(4), .ZERO_REG_HW(1'b1)) dut_z (
    .clk(clk), .rst_n(rst_n), .issue_valid(z_issue_valid), .issue_dst(z_issue_dst),
    .issue_src_a(z_issue_src_a), .issue_src_b(z_issue_src_b), .issue_ready(z_issue_ready),
    .wb_valid(z_wb_valid), .wb_addr(z_wb_addr), .wb_we(z_wb_we), .busy(z_busy),
    .busy_count(z_busy_count), .flush(z_flush), .err_spurious(z_err_spurious));

  int  n_vec = 0;
  int  n_err = 0;
  st_t ms, zs;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Register r blocks issue if a write is pending and not being retired this cycle.
  function automatic bit m_hz(st_t s, bit zhw, bit wv, int wa, int r);
    if (zhw && r == 0) return 1'b0;
    return s.busy[r] && !(wv && wa == r);
  endfunction

  function automatic bit m_ready(st_t s, bit zhw, bit fl, bit wv, int wa, int sa, int sb, int d);
    return !fl && !(m_hz(s, zhw, wv, wa, sa) || m_hz(s, zhw, wv, wa, sb) || m_hz(s, zhw, wv, wa, d));
  endfunction

  function automatic st_t m_next(st_t s, bit zhw, bit iv, bit fl, bit wv, int wa,
                                 int sa, int sb, int d);
    st_t n;
    bit  acc;
    acc    = iv && m_ready(s, zhw, fl, wv, wa, sa, sb, d);
    n.busy = s.busy;
    if (fl) n.busy = '0;
    else begin
      if (wv) n.busy[wa] = 1'b0;
      if (acc) n.busy[d] = 1'b1;
    end
    if (zhw) n.busy[0] = 1'b0;
    n.we = '0;
    if (wv && !(zhw && wa == 0)) n.we[wa] = 1'b1;
    n.err = s.err || (wv && !fl && !s.busy[wa] && !(zhw && wa == 0));
    return n;
  endfunction

  // One cycle for both instances; called at a falling edge, returns at the next one.
  task automatic step(input bit iv, input int d, input int sa, input int sb,
                      input bit wv, input int wa, input bit fl,
                      input bit ziv, input int zd, input int zsa, input int zsb,
                      input bit zwv, input int zwa, input bit zfl);
    st_t n, zn;
    issue_valid = iv; issue_dst = 3'(d); issue_src_a = 3'(sa); issue_src_b = 3'(sb);
    wb_valid = wv; wb_addr = 3'(wa); flush = fl;
    z_issue_valid = ziv; z_issue_dst = 4'(zd); z_issue_src_a = 4'(zsa); z_issue_src_b = 4'(zsb);
    z_wb_valid = zwv; z_wb_addr = 4'(zwa); z_flush = zfl;
    #1;
    chk("issue_ready", {63'd0, issue_ready}, {63'd0, m_ready(ms, 1'b0, fl, wv, wa, sa, sb, d)});
    chk("z_issue_ready", {63'd0, z_issue_ready}, {63'd0, m_ready(zs, 1'b1, zfl, zwv, zwa, zsa, zsb, zd)});
    n  = m_next(ms, 1'b0, iv, fl, wv, wa, sa, sb, d);
    zn = m_next(zs, 1'b1, ziv, zfl, zwv, zwa, zsa, zsb, zd);
    @(posedge clk);
    ms = n;
    zs = zn;
    @(negedge clk);
    chk("busy", {56'd0, busy}, ms.busy);
    chk("busy_count", {60'd0, busy_count}, 64'($countones(ms.busy)));
    chk("wb_we", {56'd0, wb_we}, ms.we);
    chk("err_spurious", {63'd0, err_spurious}, {63'd0, ms.err});
    chk("z_busy", {48'd0, z_busy}, zs.busy);
    chk("z_busy_count", {59'd0, z_busy_count}, 64'($countones(zs.busy)));
    chk("z_wb_we", {48'd0, z_wb_we}, zs.we);
    chk("z_err_spurious", {63'd0, z_err_spurious}, {63'd0, zs.err});
  endtask

  task automatic step_m(input bit iv, input int d, input int sa, input int sb,
                        input bit wv, input int wa, input bit fl);
    step(iv, d, sa, sb, wv, wa, fl, 1'b0, 1, 1, 1, 1'b0, 1, 1'b0);
  endtask

  task automatic step_z(input bit iv, input int d, input int sa, input int sb,
                        input bit wv, input int wa, input bit fl);
    step(1'b0, 1, 1, 1, 1'b0, 1, 1'b0, iv, d, sa, sb, wv, wa, fl);
  endtask

  // Asynchronous reset asserted between edges; outputs must clear before any clock edge.
  task automatic do_reset();
    #2;
    rst_n = 1'b0;
    #1;
    chk("rst_busy", {56'd0, busy}, 64'd0);
    chk("rst_wb_we", {56'd0, wb_we}, 64'd0);
    chk("rst_count", {60'd0, busy_count}, 64'd0);
    chk("rst_err", {63'd0, err_spurious}, 64'd0);
    chk("rst_z_busy", {48'd0, z_busy}, 64'd0);
    ms = '{busy: 64'd0, we: 64'd0, err: 1'b0};
    zs = '{busy: 64'd0, we: 64'd0, err: 1'b0};
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  function automatic int pick_wb(st_t s, int nreg);
    int base;
    base = int'($urandom_range(nreg - 1));
    if ($urandom_range(3) != 0) begin
      for (int k = 0; k < nreg; k++) begin
        if (s.busy[(base + k) % nreg]) return (base + k) % nreg;
      end
    end
    return base;
  endfunction

  initial begin
    issue_valid = 1'b0; issue_dst = 3'd0; issue_src_a = 3'd0; issue_src_b = 3'd0;
    wb_valid = 1'b0; wb_addr = 3'd0; flush = 1'b0;
    z_issue_valid = 1'b0; z_issue_dst = 4'd0; z_issue_src_a = 4'd0; z_issue_src_b = 4'd0;
    z_wb_valid = 1'b0; z_wb_addr = 4'd0; z_flush = 1'b0;
    @(negedge clk);
    do_reset();

    // RAW stall and same-cycle bypass
    step_m(1'b1, 5, 0, 0, 1'b0, 0, 1'b0);
    chk("raw_busy", {56'd0, busy}, 64'h20);
    chk("raw_count", {60'd0, busy_count}, 64'd1);
    step_m(1'b1, 1, 5, 0, 1'b0, 0, 1'b0);
    step_m(1'b0, 1, 5, 0, 1'b1, 5, 1'b0);
    chk("bypass_busy", {56'd0, busy}, 64'h00);

    // Issue and writeback to the same register in one cycle
    step_m(1'b1, 3, 0, 0, 1'b0, 0, 1'b0);
    step_m(1'b1, 3, 0, 0, 1'b1, 3, 1'b0);
    chk("simul_busy", {56'd0, busy}, 64'h08);
    chk("simul_we", {56'd0, wb_we}, 64'h08);
    step_m(1'b0, 0, 0, 0, 1'b1, 3, 1'b0);

    // Flush beats issue; a later writeback is spurious
    for (int i = 0; i < 4; i++) step_m(1'b1, i, 4, 4, 1'b0, 0, 1'b0);
    chk("pre_flush_busy", {56'd0, busy}, 64'h0F);
    step_m(1'b1, 6, 0, 0, 1'b0, 0, 1'b1);
    chk("flush_busy", {56'd0, busy}, 64'h00);
    chk("flush_count", {60'd0, busy_count}, 64'd0);
    step_m(1'b0, 0, 0, 0, 1'b1, 2, 1'b0);
    chk("flush_err", {63'd0, err_spurious}, 64'd1);

    // Reset in the middle of operation
    for (int i = 0; i < 3; i++) step_m(1'b1, (i == 2) ? 5 : i + 2, 0, 0, 1'b0, 0, 1'b0);
    chk("pre_rst_busy", {56'd0, busy}, 64'h2C);
    do_reset();

    // Decode sweep
    for (int a = 0; a < 8; a++) begin
      step_m(1'b0, 0, 0, 0, 1'b1, a, 1'b0);
      chk("decode", {56'd0, wb_we}, 64'd1 << a);
    end
    step_m(1'b0, 0, 0, 0, 1'b0, 0, 1'b0);
    chk("decode_idle", {56'd0, wb_we}, 64'd0);

    // Hardwired register 0
    do_reset();
    step_z(1'b1, 0, 1, 1, 1'b0, 0, 1'b0);
    chk("z_r0_busy", {48'd0, z_busy}, 64'd0);
    step_z(1'b1, 7, 0, 0, 1'b0, 0, 1'b0);
    step_z(1'b0, 0, 0, 0, 1'b1, 0, 1'b0);
    chk("z_r0_we", {48'd0, z_wb_we}, 64'd0);
    chk("z_r0_err", {63'd0, z_err_spurious}, 64'd0);

    // Randomized traffic, periodically reset so the sticky flag is re-exercised
    for (int blk = 0; blk < 16; blk++) begin
      do_reset();
      for (int c = 0; c < 150; c++) begin
        step($urandom_range(9) < 6, int'($urandom_range(7)), int'($urandom_range(7)),
             int'($urandom_range(7)), $urandom_range(9) < 5, pick_wb(ms, 8), $urandom_range(39) == 0,
             $urandom_range(9) < 6, int'($urandom_range(15)), int'($urandom_range(15)),
             int'($urandom_range(15)), $urandom_range(9) < 5, pick_wb(zs, 16), $urandom_range(39) == 0);
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/regdec_scoreboard.md
Name: regdec_scoreboard

Overview:
- Parametrised successor to the team's fixed 3-to-8 gate decoder.
- Decodes an N-bit register address into a 2^N one-hot write-enable vector, registered for the writeback stage.
- Keeps a per-register pending-write scoreboard and raises issue stalls on RAW/WAW hazards.
- Sits between decode/issue and the register file of the RISC pipeline.

Parameters:
- ADDR_W, 3, register address width; NREG = 2**ADDR_W registers.
- ZERO_REG_HW, 0, when 1 register 0 is hardwired: never busy, never stalls, never write-enabled.

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous active-low reset.
- issue_valid  in  1  instruction presented for issue.
- issue_dst  in  ADDR_W  destination register of the presented instruction.
- issue_src_a  in  ADDR_W  source register A.
- issue_src_b  in  ADDR_W  source register B.
- issue_ready  out  1  combinational; issue is accepted when issue_valid & issue_ready.
- wb_valid  in  1  writeback of a completed instruction.
- wb_addr  in  ADDR_W  writeback destination.
- wb_we  out  NREG  registered one-hot register-file write enable.
- busy  out  NREG  registered scoreboard bits.
- busy_count  out  ADDR_W+1  registered popcount of busy.
- flush  in  1  pipeline flush; discards all pending writes.
- err_spurious  out  1  sticky flag: writeback to a non-busy register.

Behaviour:
- Reset: rst_n low asynchronously forces wb_we=0, busy=0, busy_count=0, err_spurious=0. Held state persists until the first clk edge after rst_n rises.
- Decode function: onehot(a) has bit a set and all other bits clear. It applies to any ADDR_W from 1 to 6.
- wb_we latency is 1 cycle:
  - wb_valid=1 in cycle t gives wb_we = onehot(wb_addr) in t+1.
  - Otherwise wb_we = 0.
  - With ZERO_REG_HW=1 and wb_addr=0, wb_we stays 0.
  - wb_we is independent of flush and of busy.
- Writeback bypass: wb_hit(r) = wb_valid & (wb_addr==r). It is combinational and same-cycle.
- Hazards, all combinational:
  - hz(r) = busy[r] & ~wb_hit(r).
  - With ZERO_REG_HW=1, hz(0)=0.
  - issue_ready = ~flush & ~(hz(issue_src_a) | hz(issue_src_b) | hz(issue_dst)).
  - issue_ready depends on the address inputs even when issue_valid=0.
- Scoreboard update on each clk edge, applied per register r in priority order:
  1. flush=1: busy[r] <= 0. Any issue attempted in that cycle is not accepted.
  2. Otherwise, accepted issue with issue_dst==r: busy[r] <= 1. Same-cycle wb_hit(r) does not clear it; the new write is pending.
  3. Otherwise, wb_hit(r): busy[r] <= 0.
  4. Otherwise: hold.
  - With ZERO_REG_HW=1, busy[0] stays 0 always.
- WAW: the dst hazard ensures at most one pending write per register, so one bit per register is sufficient.
- busy_count: registered popcount of the next busy value, so it always matches busy in the same cycle.
- err_spurious: set on a clk edge when wb_valid=1, flush=0, busy[wb_addr]=0, and the address is not hardwired reg 0. It clears only on reset.
  - A writeback arriving after a flush sets err_spurious; issue logic must gate that.
  - With ZERO_REG_HW=0, reg 0 behaves like any other register.
- No internal FSM beyond the scoreboard. Throughput is one issue and one writeback per cycle.

Test Plan:
- Reset mid-operation: busy=8'h2C, assert rst_n=0 between edges -> busy, wb_we and busy_count read 0 immediately, err_spurious=0.
- Decode sweep (ADDR_W=3): wb_valid=1 with wb_addr 0..7 on consecutive cycles -> wb_we = 01,02,04,...,80, each one cycle later. wb_valid=0 -> wb_we=00.
- RAW stall and bypass:
  - Issue dst=5 accepted -> busy=8'h20, count=1.
  - Next cycle, src_a=5 with no wb -> issue_ready=0.
  - Same src_a=5 with wb_valid=1, wb_addr=5 -> issue_ready=1.
  - Following edge: busy=8'h00 if the new dst≠5.
- Simultaneous issue/writeback, same reg: busy[3]=1, issue dst=3 with wb_addr=3 in the same cycle -> accepted, busy[3] stays 1, wb_we=08 next cycle.
- Flush priority: busy=8'h0F, flush=1 together with issue_valid dst=6 -> issue_ready=0, next busy=00, count=0. A later wb_addr=2 -> err_spurious=1.
- ZERO_REG_HW=1, ADDR_W=4: issue dst=0 then src_a=0 -> never stalls, busy[0]=0. wb_addr=0 -> wb_we=16'h0000, err_spurious stays 0.
